// File: rtl/coprocessor_io_sequencer_if.sv
// Nios-side Avalon-MM register port and coprocessor IO bus of the IO sequencer.
// The sequencer takes the slave view; the Nios bus and the coprocessor together take the master view.
interface coprocessor_io_sequencer_if #(
    parameter int ADDR_W = 15
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic              read_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;
    logic [ADDR_W-1:0] cp_addr;
    logic [31:0]       cp_wdata;
    logic              cp_rd;
    logic              cp_wr;
    logic [31:0]       cp_rdata;
    logic              cp_ack;

    modport slave (
        input  address, chipselect, write_n, read_n, writedata, cp_rdata, cp_ack,
        output readdata, irq, cp_addr, cp_wdata, cp_rd, cp_wr
    );

    modport master (
        output address, chipselect, write_n, read_n, writedata, cp_rdata, cp_ack,
        input  readdata, irq, cp_addr, cp_wdata, cp_rd, cp_wr
    );
endinterface

// File: rtl/coprocessor_io_sequencer.sv
// Runs single read/write transactions on the coprocessor IO bus on behalf of the Nios,
// with an acknowledge timeout, optional address auto-increment and a completion interrupt.
//
// state  | meaning
// IDLE   | waiting for a start request from a CTRL write
// SETUP  | address and data stable, no strobe; timeout counter loads
// STROBE | cp_rd or cp_wr asserted, waiting for cp_ack or timeout
// HOLD   | strobes low, DONE sets, optional address increment
module coprocessor_io_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 15
) (
    input  logic                        clk,
    input  logic                        reset_n,
    coprocessor_io_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [15:0]       tmo_cnt_q;
    logic              autoinc_q, ie_q, done_q, timeout_q, overrun_q;
    logic              start_pend_q, dir_rd_q;
    logic              acked, expired, stb_rd, stb_wr;
    logic              busy, wr_en, wr_ctrl, start_req, start_ok;
    logic              unused_read_n;

    assign unused_read_n = bus.read_n;

    assign busy      = (state_q != IDLE);
    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wr_ctrl   = wr_en & (bus.address == 2'd2);
    assign start_req = wr_ctrl & (bus.writedata[0] | bus.writedata[1]);
    // A start still waiting to be picked up by IDLE counts as an overrun too.
    assign start_ok  = start_req & ~busy & ~start_pend_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        acked     = 1'b0;
        expired   = 1'b0;
        stb_rd    = 1'b0;
        stb_wr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_pend_q) state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = STROBE;
            end
            STROBE: begin
                stb_rd = dir_rd_q;
                stb_wr = ~dir_rd_q;
                if (bus.cp_ack) begin
                    acked     = 1'b1;
                    state_nxt = HOLD;
                end else if (tmo_cnt_q == 16'd0) begin
                    expired   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            tmo_cnt_q    <= '0;
            autoinc_q    <= 1'b0;
            ie_q         <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            overrun_q    <= 1'b0;
            start_pend_q <= 1'b0;
            dir_rd_q     <= 1'b0;
        end else begin
            if (wr_en && !busy && bus.address == 2'd0) addr_q  <= bus.writedata[ADDR_W-1:0];
            if (wr_en && !busy && bus.address == 2'd1) wdata_q <= bus.writedata;

            if (wr_ctrl) begin
                autoinc_q <= bus.writedata[4];
                ie_q      <= bus.writedata[5];
                if (bus.writedata[8]) begin
                    done_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    overrun_q <= 1'b0;
                end
            end

            if (state_q == IDLE && start_pend_q) start_pend_q <= 1'b0;
            if (start_ok) begin
                start_pend_q <= 1'b1;
                dir_rd_q     <= bus.writedata[0];
                done_q       <= 1'b0;
                timeout_q    <= 1'b0;
            end

            // Event sets come last so they win over a same-cycle clear.
            if (start_req && !start_ok) overrun_q <= 1'b1;

            // Down-counter: terminal count 0 marks the last allowed strobe cycle.
            if (state_q == SETUP) begin
                tmo_cnt_q <= TMO_LOAD;
            end else if (state_q == STROBE && tmo_cnt_q != 16'd0) begin
                tmo_cnt_q <= tmo_cnt_q - 16'd1;
            end

            if (acked && dir_rd_q) rdata_q <= bus.cp_rdata;
            if (expired) timeout_q <= 1'b1;

            if (state_q == HOLD) begin
                done_q <= 1'b1;
                if (autoinc_q) addr_q <= addr_q + ADDR_W'(1);
            end
        end
    end

    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0: bus.readdata = {{(32-ADDR_W){1'b0}}, addr_q};
            2'd1: bus.readdata = wdata_q;
            2'd2: bus.readdata = {26'd0, ie_q, autoinc_q, overrun_q, timeout_q, done_q, busy};
            2'd3: bus.readdata = rdata_q;
            default: bus.readdata = 32'd0;
        endcase
    end

    assign bus.irq      = ie_q & done_q;
    assign bus.cp_addr  = addr_q;
    assign bus.cp_wdata = wdata_q;
    assign bus.cp_rd    = stb_rd;
    assign bus.cp_wr    = stb_wr;
endmodule

// File: tb/tb_coprocessor_io_sequencer.sv
// Directed bench for coprocessor_io_sequencer: a small coprocessor responder acks after a
// programmable number of strobe cycles and records strobe length, address and data.
module tb_coprocessor_io_sequencer;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;
    int   cyc;
    int   ack_after;
    int   stb_len, last_len, stb_total, rise_cyc;
    logic [14:0] last_addr;
    logic [31:0] last_wdata;
    logic        last_was_wr;
    int   w0;
    int   base;
    logic [31:0] d;

    coprocessor_io_sequencer_if #(.ADDR_W(15)) bus ();

    coprocessor_io_sequencer #(.TIMEOUT_CYCLES(4), .ADDR_W(15)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Coprocessor model: samples the strobes shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (bus.cp_rd || bus.cp_wr) begin
            stb_len = stb_len + 1;
            if (stb_len == 1) rise_cyc = cyc;
            stb_total   = stb_total + 1;
            last_len    = stb_len;
            last_addr   = bus.cp_addr;
            last_wdata  = bus.cp_wdata;
            last_was_wr = bus.cp_wr;
            bus.cp_ack  = (ack_after != 0) && (stb_len == ack_after);
        end else begin
            stb_len    = 0;
            bus.cp_ack = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_bad = n_bad + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = v;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        w0 = cyc;
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] v);
        bus.address = a;
        #1;
        v = bus.readdata;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; ack_after = 0;
        stb_len = 0; last_len = 0; stb_total = 0; rise_cyc = 0;
        last_addr = '0; last_wdata = '0; last_was_wr = 1'b0; w0 = 0;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.read_n = 1'b1;
        bus.writedata = '0; bus.cp_rdata = '0; bus.cp_ack = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), d);
            check($sformatf("reset_reg%0d", i), d, 32'h0);
        end
        check("reset_cp_rd", 32'(bus.cp_rd), 32'h0);
        check("reset_cp_wr", 32'(bus.cp_wr), 32'h0);
        check("reset_cp_addr", 32'(bus.cp_addr), 32'h0);
        check("reset_irq", 32'(bus.irq), 32'h0);

        // Write transaction, ack on the third strobe cycle
        bus_write(2'd0, 32'hFFFF_1234);
        bus_write(2'd1, 32'hDEAD_BEEF);
        peek(2'd0, d); check("addr_readback", d, 32'h0000_1234);
        peek(2'd1, d); check("wdata_readback", d, 32'hDEAD_BEEF);
        ack_after = 3;
        bus_write(2'd2, 32'h02);
        repeat (10) @(negedge clk);
        check("wr_strobe_len", 32'(last_len), 32'd3);
        check("wr_dir", 32'(last_was_wr), 32'd1);
        check("wr_cp_addr", 32'(last_addr), 32'h1234);
        check("wr_cp_wdata", last_wdata, 32'hDEAD_BEEF);
        check("wr_rise_delay", 32'(rise_cyc - w0), 32'd2);
        peek(2'd2, d); check("wr_status", d, 32'h02);

        // Read, ack in first strobe cycle: DONE appears four edges after the write
        bus_write(2'd0, 32'h0010);
        bus.cp_rdata = 32'h1111_2222;
        ack_after = 1;
        bus_write(2'd2, 32'h01);
        repeat (3) @(negedge clk);
        peek(2'd2, d); check("rd_status_busy", d, 32'h01);
        @(negedge clk);
        peek(2'd2, d); check("rd_status_done", d, 32'h02);
        peek(2'd3, d); check("rd_rdata", d, 32'h1111_2222);
        check("rd_dir", 32'(last_was_wr), 32'd0);

        // Auto-increment wraps 0x7FFF to 0
        bus_write(2'd0, 32'h7FFF);
        bus.cp_rdata = 32'hCAFE_F00D;
        ack_after = 2;
        bus_write(2'd2, 32'h11);
        repeat (10) @(negedge clk);
        check("ai_cp_addr", 32'(last_addr), 32'h7FFF);
        peek(2'd3, d); check("ai_rdata", d, 32'hCAFE_F00D);
        peek(2'd0, d); check("ai_addr_wrap", d, 32'h0000);
        peek(2'd2, d); check("ai_status", d, 32'h12);

        // Timeout: no ack, four strobe cycles, RDATA untouched
        bus.cp_rdata = 32'h9999_9999;
        ack_after = 0;
        bus_write(2'd2, 32'h01);
        repeat (12) @(negedge clk);
        check("to_strobe_len", 32'(last_len), 32'd4);
        peek(2'd2, d); check("to_status", d, 32'h06);
        peek(2'd3, d); check("to_rdata", d, 32'hCAFE_F00D);
        peek(2'd0, d); check("to_addr", d, 32'h0000);

        // Writes while busy: start gives OVERRUN, ADDR write ignored
        bus_write(2'd0, 32'h0020);
        base = stb_total;
        bus_write(2'd2, 32'h02);
        @(negedge clk);
        bus_write(2'd2, 32'h01);
        bus_write(2'd0, 32'h0055);
        repeat (20) @(negedge clk);
        check("ov_single_txn", 32'(stb_total - base), 32'd4);
        check("ov_dir", 32'(last_was_wr), 32'd1);
        peek(2'd2, d); check("ov_status", d, 32'h0E);
        peek(2'd0, d); check("ov_addr", d, 32'h0020);
        bus_write(2'd2, 32'h100);
        peek(2'd2, d); check("clr_status", d, 32'h00);

        // Interrupt follows DONE in the same cycle
        bus_write(2'd2, 32'h20);
        peek(2'd2, d); check("ie_status", d, 32'h20);
        check("ie_irq_idle", 32'(bus.irq), 32'd0);
        ack_after = 1;
        bus_write(2'd2, 32'h21);
        repeat (3) @(negedge clk);
        check("irq_before", 32'(bus.irq), 32'd0);
        @(negedge clk);
        peek(2'd2, d); check("irq_status", d, 32'h22);
        check("irq_rise", 32'(bus.irq), 32'd1);
        bus_write(2'd2, 32'h120);
        check("irq_clear", 32'(bus.irq), 32'd0);

        // Asynchronous reset in the middle of a strobe
        bus_write(2'd0, 32'h0300);
        bus_write(2'd1, 32'h0000_5A5A);
        ack_after = 0;
        bus_write(2'd2, 32'h21);
        repeat (2) @(negedge clk);
        check("mid_cp_rd", 32'(bus.cp_rd), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_cp_rd", 32'(bus.cp_rd), 32'd0);
        check("rst_cp_wr", 32'(bus.cp_wr), 32'd0);
        check("rst_cp_addr", 32'(bus.cp_addr), 32'h0);
        check("rst_irq", 32'(bus.irq), 32'd0);
        for (int i = 0; i < 4; i++) begin
            peek(2'(i), d);
            check($sformatf("rst_reg%0d", i), d, 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        base = stb_total;
        repeat (6) @(negedge clk);
        check("post_rst_no_strobe", 32'(stb_total - base), 32'd0);
        peek(2'd2, d); check("post_rst_status", d, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
